// File: rtl/adc_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adc_spi_responder
//  Brief    : ADC128S022-style SPI slave emulator. Serves programmable 12-bit
//             channel values to an SPI master and captures the channel address
//             for the following frame.
//  Revision : 1.0  initial release
// ============================================================================
module adc_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  adc_cs_n,
    input  logic                  adc_sclk,
    input  logic                  adc_saddr,
    output logic                  adc_sdat,
    input  logic [8*DATA_W-1:0]   ch_value,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic [2:0]            cur_channel
);

    localparam int FRAME_W = 4 + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] c_cnt_sat  = CNT_W'(FRAME_W + 1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_saddr_sync;
    logic [SYNC_STAGES-1:0] r_vld;
    logic                   r_cs_d;
    logic                   r_sclk_d;

    logic [0:0]             r_state;
    logic [CNT_W-1:0]       r_count;
    logic [FRAME_W-1:0]     r_shift;
    logic [2:0]             r_addr_cap;
    logic [2:0]             r_cur_channel;
    logic                   r_sdat;
    logic                   r_done;
    logic                   r_error;
    logic                   r_armed;

    logic                   w_cs;
    logic                   w_sclk;
    logic                   w_saddr;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_sclk_fall;
    logic                   w_sclk_rise;
    logic [DATA_W-1:0]      w_ch_sel;

    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_saddr     = r_saddr_sync[SYNC_STAGES-1];
    assign w_cs_fall   = r_cs_d & ~w_cs;
    assign w_cs_rise   = ~r_cs_d & w_cs;
    assign w_sclk_fall = r_sclk_d & ~w_sclk;
    assign w_sclk_rise = ~r_sclk_d & w_sclk;
    assign w_ch_sel    = ch_value[r_cur_channel*DATA_W +: DATA_W];

    assign adc_sdat    = r_sdat;
    assign frame_done  = r_done;
    assign frame_error = r_error;
    assign cur_channel = r_cur_channel;

    // Pin synchronizers plus one edge-detect flop; r_vld marks when the chain
    // carries post-reset pin samples rather than reset values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_sync    <= '1;
            r_sclk_sync  <= '1;
            r_saddr_sync <= '0;
            r_vld        <= '0;
            r_cs_d       <= 1'b1;
            r_sclk_d     <= 1'b1;
        end else begin
            r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], adc_cs_n};
            r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], adc_sclk};
            r_saddr_sync <= {r_saddr_sync[SYNC_STAGES-2:0], adc_saddr};
            r_vld        <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_cs_d       <= w_cs;
            r_sclk_d     <= w_sclk;
        end
    end

    // Frame engine: snapshot on cs_n fall, count/capture on rises, shift on
    // falls, judge the frame on cs_n rise (which overrides any same-cycle edge).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_count       <= '0;
            r_shift       <= '0;
            r_addr_cap    <= 3'd0;
            r_cur_channel <= 3'd0;
            r_sdat        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_armed       <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            // A cs_n that was already low at reset release must first be seen
            // high before a fall can open a frame.
            if (!r_armed && r_vld[SYNC_STAGES-1] && w_cs) begin
                r_armed <= 1'b1;
            end
            if (r_state == c_st_idle) begin
                if (r_armed && w_cs_fall) begin
                    r_state    <= c_st_shift;
                    r_shift    <= {4'b0000, w_ch_sel};
                    r_sdat     <= 1'b0;
                    r_count    <= '0;
                    r_addr_cap <= r_cur_channel;
                end
            end else begin
                if (w_cs_rise) begin
                    r_state <= c_st_idle;
                    if (r_count == c_cnt_full) begin
                        r_done        <= 1'b1;
                        r_cur_channel <= r_addr_cap;
                    end else begin
                        r_error <= 1'b1;
                    end
                    r_sdat  <= 1'b0;
                    r_count <= '0;
                end else if (w_sclk_rise) begin
                    if (r_count != c_cnt_sat) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    if (r_count == CNT_W'(2)) r_addr_cap[2] <= w_saddr;
                    if (r_count == CNT_W'(3)) r_addr_cap[1] <= w_saddr;
                    if (r_count == CNT_W'(4)) r_addr_cap[0] <= w_saddr;
                end else if (w_sclk_fall && (r_count != '0)) begin
                    r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                    r_sdat  <= r_shift[FRAME_W-2];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_adc_spi_responder
//  Brief    : Self-checking bench for adc_spi_responder: directed scenarios
//             followed by randomized frames against a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_spi_responder;

    localparam int SYNC_STAGES = 2;
    localparam int DATA_W      = 12;
    localparam int SCLK_HALF   = 50;

    logic               clk = 1'b0;
    logic               reset;
    logic               adc_cs_n;
    logic               adc_sclk;
    logic               adc_saddr;
    logic               adc_sdat;
    logic [8*DATA_W-1:0] ch_value;
    logic               frame_done;
    logic               frame_error;
    logic [2:0]         cur_channel;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    // Frame-level reference model: channel table and selected channel.
    logic [11:0] m_ch [8];
    logic [2:0]  m_cur;

    adc_spi_responder #(
        .SYNC_STAGES (SYNC_STAGES),
        .DATA_W      (DATA_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .adc_saddr   (adc_saddr),
        .adc_sdat    (adc_sdat),
        .ch_value    (ch_value),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .cur_channel (cur_channel)
    );

    always #5 clk = ~clk;

    // Count pulse cycles; a stuck pulse shows up as a count above one.
    always @(negedge clk) begin
        if (frame_done === 1'b1)  done_cnt++;
        if (frame_error === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int n, input logic [11:0] v);
        ch_value[n*DATA_W +: DATA_W] = v;
    endtask

    // Drive one SPI frame with nrises SCLK pulses; returns the DOUT bits
    // sampled at each rise, first bit in the most significant position.
    task automatic do_frame(input int nrises, input logic [2:0] addr, input int change_at,
                            input int change_ch, input logic [11:0] new_val,
                            output logic [31:0] rx);
        logic [15:0] din;
        din = {2'b00, addr, 11'b0};
        rx  = '0;
        @(negedge clk);
        adc_cs_n = 1'b0;
        #SCLK_HALF;
        for (int k = 1; k <= nrises; k++) begin
            adc_sclk  = 1'b0;
            adc_saddr = (k <= 16) ? din[16-k] : 1'b0;
            if (k == change_at) set_ch(change_ch, new_val);
            #SCLK_HALF;
            rx = {rx[30:0], adc_sdat};
            adc_sclk = 1'b1;
            #SCLK_HALF;
        end
        adc_cs_n  = 1'b1;
        adc_saddr = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
    endtask

    // Run a frame and check it against the model.
    task automatic check_frame(input string tag, input int nrises, input logic [2:0] addr,
                               input int change_at, input logic [11:0] new_val);
        logic [31:0] rx;
        logic [31:0] word;
        logic [31:0] exp;
        int          d0;
        int          e0;
        int          sel;
        bit          ok;
        sel  = int'(m_cur);
        word = {20'd0, 4'b0000, m_ch[sel]};
        d0   = done_cnt;
        e0   = err_cnt;
        do_frame(nrises, addr, change_at, sel, new_val, rx);
        if (change_at >= 1 && change_at <= nrises) m_ch[sel] = new_val;
        exp = (nrises <= 16) ? (word >> (16 - nrises)) : (word << (nrises - 16));
        ok  = (nrises == 16);
        if (ok) m_cur = addr;
        chk({tag, ".dout"}, rx, exp);
        chk({tag, ".done"}, 32'(done_cnt - d0), ok ? 32'd1 : 32'd0);
        chk({tag, ".err"},  32'(err_cnt - e0),  ok ? 32'd0 : 32'd1);
        chk({tag, ".cur"},  {29'd0, cur_channel}, {29'd0, m_cur});
        chk({tag, ".sdat"}, {31'd0, adc_sdat}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0;
        int e0;
        int nr;
        int ca;
        logic [31:0] rx_dummy;

        reset     = 1'b1;
        adc_cs_n  = 1'b1;
        adc_sclk  = 1'b1;
        adc_saddr = 1'b0;
        ch_value  = '0;
        for (int i = 0; i < 8; i++) m_ch[i] = 12'h000;
        m_cur = 3'd0;
        repeat (5) @(negedge clk);

        chk("rst.sdat",  {31'd0, adc_sdat},    32'd0);
        chk("rst.done",  {31'd0, frame_done},  32'd0);
        chk("rst.err",   {31'd0, frame_error}, 32'd0);
        chk("rst.cur",   {29'd0, cur_channel}, 32'd0);

        reset = 1'b0;
        repeat (6) @(negedge clk);

        // Basic ch0 read.
        set_ch(0, 12'hA5C); m_ch[0] = 12'hA5C;
        set_ch(5, 12'h3FF); m_ch[5] = 12'h3FF;
        check_frame("t1", 16, 3'd0, 0, 12'h000);

        // Address capture then read of the newly selected channel.
        check_frame("t2a", 16, 3'd5, 0, 12'h000);
        check_frame("t2b", 16, 3'd5, 0, 12'h000);

        // Short and long frames.
        check_frame("t3", 10, 3'd2, 0, 12'h000);
        check_frame("t4", 18, 3'd1, 0, 12'h000);

        // Mid-frame value change on the selected channel.
        check_frame("t5a", 16, 3'd0, 0, 12'h000);
        set_ch(0, 12'h123); m_ch[0] = 12'h123;
        check_frame("t5b", 16, 3'd0, 8, 12'hFFF);
        chk("t5.model", {20'd0, m_ch[0]}, 32'h0FFF);

        // Reset in the middle of a frame.
        check_frame("t6a", 16, 3'd3, 0, 12'h000);
        @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        adc_cs_n = 1'b0;
        #SCLK_HALF;
        for (int k = 0; k < 8; k++) begin
            adc_sclk = 1'b0; #SCLK_HALF;
            adc_sclk = 1'b1; #SCLK_HALF;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("t6.sdat_rst", {31'd0, adc_sdat}, 32'd0);
            @(negedge clk);
        end
        adc_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_cur = 3'd0;
        repeat (8) @(negedge clk);
        chk("t6.pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        chk("t6.cur", {29'd0, cur_channel}, 32'd0);
        check_frame("t6b", 16, 3'd6, 0, 12'h000);

        // cs_n held low across reset release: no frame until a real fall.
        reset    = 1'b1;
        adc_cs_n = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_cur = 3'd0;
        d0 = done_cnt;
        e0 = err_cnt;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            adc_sclk = 1'b0; #SCLK_HALF;
            adc_sclk = 1'b1; #SCLK_HALF;
        end
        adc_cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t7.pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        chk("t7.cur", {29'd0, cur_channel}, 32'd0);
        check_frame("t7b", 16, 3'd4, 0, 12'h000);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < 8; i++) begin
                    m_ch[i] = 12'($urandom);
                    set_ch(i, m_ch[i]);
                end
            end
            nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 18)) : 16;
            ca = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, nr));
            check_frame("rnd", nr, 3'($urandom), ca, 12'($urandom));
        end

        rx_dummy = '0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
